// File: rtl/hm_mem_reader.sv
// Burst read engine for port B of the hm dual-port memory: takes a (start word, length)
// command, issues sequential reads and streams the words out with a last marker.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a command; zero-length commands are consumed here
// S_RUN   | issuing reads while words remain and the output buffer has room
// S_DRAIN | all reads issued; waiting for the buffer to empty
module hm_mem_reader #(
    parameter int DEPTH_W    = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DEPTH_W-1:0] cmd_addr,
    input  logic [DEPTH_W:0]   cmd_len,
    output logic [15:0]        mem_addr,
    output logic [3:0]         mem_we,
    output logic [31:0]        mem_di,
    input  logic [31:0]        mem_do,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic               rd_last,
    output logic               busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [DEPTH_W-1:0] r_word;
    logic [DEPTH_W:0]   r_remain;
    logic               r_inflight;
    logic               r_inflight_last;
    logic               r_cmd_ready;
    logic               r_busy;
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic               r_fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_pop;
    logic               w_push;
    logic [CNT_W:0]     w_occ;
    logic               w_room;
    logic               w_issue;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop  = (r_count != '0) && rd_ready;
    assign w_push = r_inflight;
    assign w_occ  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    // A pop in the same cycle frees a slot, which keeps one word per cycle flowing.
    assign w_room  = w_pop ? (w_occ <= OCC_MAX) : (w_occ < OCC_MAX);
    assign w_issue = (r_state == S_RUN) && (r_remain != '0) && w_room;

    assign mem_addr  = 16'({r_word, 5'b00000});
    assign mem_we    = 4'b0000;
    assign mem_di    = 32'd0;
    assign rd_valid  = (r_count != '0);
    assign rd_data   = r_fifo_data[r_rd_ptr];
    assign rd_last   = rd_valid & r_fifo_last[r_rd_ptr];
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state         <= S_IDLE;
            r_word          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_cmd_ready     <= 1'b0;
            r_busy          <= 1'b0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remain == (DEPTH_W+1)'(1));

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= mem_do;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
                if (r_fifo_last[r_rd_ptr]) begin
                    r_busy <= 1'b0;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready && (cmd_len != '0)) begin
                        r_word      <= cmd_addr;
                        r_remain    <= cmd_len;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cmd_ready <= 1'b0;
                    if (w_issue) begin
                        r_word   <= r_word + DEPTH_W'(1);
                        r_remain <= r_remain - (DEPTH_W+1)'(1);
                        if (r_remain == (DEPTH_W+1)'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_cmd_ready <= 1'b0;
                    if ((r_count == '0) && !r_inflight) begin
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hm_mem_reader.sv
// Scoreboarded bench for hm_mem_reader: accepted commands push expected words computed
// from the memory init pattern; a monitor pops and compares on every stream transfer.
module tb_hm_mem_reader;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_addr = '0;
    logic [10:0] cmd_len = '0;
    logic [15:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_di;
    logic [31:0] mem_do = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        rd_last;
    logic        busy;

    hm_mem_reader #(.DEPTH_W(10), .FIFO_DEPTH(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_di    (mem_di),
        .mem_do    (mem_do),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          last_xfer_edge = 0;
    int          n_xfers = 0;
    int          rdy_mode = 0;
    int          pat = 0;
    logic        stalled = 1'b0;
    logic [31:0] held_d = '0;
    logic        held_l = 1'b0;

    // Memory content: byte d holds d mod 256, little-endian within each word.
    function automatic logic [31:0] exp_word(input int w);
        int b;
        b = ((w % 1024) * 4) % 256;
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge sys_clk) cyc++;

    // Port-B memory: registered read, one cycle of latency.
    always @(posedge sys_clk) mem_do <= exp_word(int'(mem_addr[14:5]));

    always @(posedge sys_clk) begin
        #1;
        case (rdy_mode)
            0:       rd_ready = 1'b1;
            1: begin
                rd_ready = (pat % 3 == 0);
                pat++;
            end
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge sys_clk) begin
        if (sys_rst_n && cmd_valid && cmd_ready) begin
            chk("accept_while_busy", {31'd0, busy}, 32'd0);
            accept_cyc = cyc + 1;
            for (int i = 0; i < int'(cmd_len); i++) begin
                sbq.push_back('{d: exp_word(int'(cmd_addr) + i), l: (i == int'(cmd_len) - 1)});
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            sbq.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", {31'd0, rd_valid}, 32'd1);
                chk("stall_data", rd_data, held_d);
                chk("stall_last", {31'd0, rd_last}, {31'd0, held_l});
            end
            if (rd_valid && rd_ready) begin
                n_xfers++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%08h expected no transfer", rd_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_last", {31'd0, rd_last}, {31'd0, e.l});
                end
                if (rd_last) last_xfer_edge = cyc - accept_cyc + 1;
            end
            stalled = rd_valid && !rd_ready;
            held_d  = rd_data;
            held_l  = rd_last;
        end
    end

    task automatic send_cmd(input int a, input int l, output int waited);
        logic done;
        done = 1'b0;
        waited = 0;
        @(posedge sys_clk);
        #1;
        cmd_addr  = 10'(a);
        cmd_len   = 11'(l);
        cmd_valid = 1'b1;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge sys_clk);
            if (cmd_ready) done = 1'b1;
            else waited++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_timeout: got no accept expected accept within 5000 cycles");
        end
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge sys_clk);
            if (sbq.size() == 0 && !busy && !rd_valid && cmd_ready) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got %0d pending words busy=%0b expected idle", sbq.size(), busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        int tot;
        logic ok;

        repeat (3) @(negedge sys_clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Two-word burst: latency, busy and cmd_ready timing.
        rdy_mode = 0;
        send_cmd(0, 2, w);
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge sys_clk);
            if (rd_valid) ok = 1'b1;
        end
        chk("first_latency", cyc - accept_cyc, 2);
        chk("busy_during", {31'd0, busy}, 32'd1);
        @(negedge sys_clk);
        chk("busy_last_word", {31'd0, busy}, 32'd1);
        @(negedge sys_clk);
        chk("busy_after_last", {31'd0, busy}, 32'd0);
        chk("cmd_ready_drain", {31'd0, cmd_ready}, 32'd0);
        @(negedge sys_clk);
        chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("last_edge_len2", last_xfer_edge, 4);

        // Wrap from the top word back to word 0.
        send_cmd(1023, 2, w);
        @(negedge sys_clk);
        chk("wrap_addr0", {16'd0, mem_addr}, 32'h7FE0);
        @(negedge sys_clk);
        chk("wrap_addr1", {16'd0, mem_addr}, 32'h0000);
        wait_idle(50);

        // Backpressure pattern 1,0,0.
        rdy_mode = 1;
        base = n_xfers;
        send_cmd(4, 8, w);
        wait_idle(200);
        chk("bp_count", n_xfers - base, 8);

        // Zero-length command.
        rdy_mode = 0;
        base = n_xfers;
        send_cmd(5, 0, w);
        chk("len0_wait", w, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            chk("len0_valid", {31'd0, rd_valid}, 32'd0);
            chk("len0_busy", {31'd0, busy}, 32'd0);
        end
        chk("len0_count", n_xfers - base, 0);

        // Full-memory burst.
        base = n_xfers;
        send_cmd(0, 1024, w);
        wait_idle(3000);
        chk("full_count", n_xfers - base, 1024);
        chk("full_last_edge", last_xfer_edge, 1026);

        // Reset during the third word of an 8-word burst.
        base = n_xfers;
        send_cmd(100, 8, w);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(posedge sys_clk);
            #1;
            if (n_xfers - base >= 2) ok = 1'b1;
        end
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("abort_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        base = n_xfers;
        send_cmd(0, 1, w);
        wait_idle(50);
        chk("post_abort_count", n_xfers - base, 1);

        // Command held high through a burst.
        rdy_mode = 2;
        base = n_xfers;
        @(posedge sys_clk);
        #1;
        cmd_addr  = 10'd200;
        cmd_len   = 11'd5;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge sys_clk);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge sys_clk);
        #1;
        cmd_addr = 10'd1020;
        cmd_len  = 11'd6;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge sys_clk);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("holdoff_count", n_xfers - base, 11);

        // Random commands and random downstream readiness.
        base = n_xfers;
        tot = 0;
        for (int n = 0; n < 24; n++) begin
            int a;
            int l;
            rdy_mode = int'($urandom_range(0, 2));
            a = int'($urandom_range(0, 1023));
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            tot += l;
            send_cmd(a, l, w);
        end
        wait_idle(3000);
        chk("random_count", n_xfers - base, tot);

        chk("mem_we", {28'd0, mem_we}, 32'd0);
        chk("mem_di", mem_di, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hm_mem_reader.md
Name: hm_mem_reader

Overview:
- Burst read engine on port B of the 32-bit dual-port hm memory.
- Accepts a (start word, length) command, issues sequential word reads, and absorbs the memory's 1-cycle registered read latency.
- Delivers the words as a valid/ready stream with a last marker to the downstream dump/export logic.
- Port A stays with the writer side; this block never writes.

Parameters:
- DEPTH_W, 10, word-address width (memory holds 2^DEPTH_W 32-bit words = 4096 bytes).
- FIFO_DEPTH, 2, output buffer entries (fixed at 2; 1-cycle latency needs exactly 2 for full throughput).

Ports:
- sys_clk  in  1  single clock; also drives memory CLKB.
- sys_rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  DEPTH_W  start word index.
- cmd_len  in  DEPTH_W+1  words to read, 0..1024.
- mem_addr  out  16  to ADDRB; = {1'b0, word, 5'b00000} (bits 14:3 = byte index = word*4).
- mem_we  out  4  to WEB; constant 4'b0000.
- mem_di  out  32  to DIB; constant 0.
- mem_do  in  32  from DOB; valid the cycle after mem_addr is presented.
- rd_data  out  32  stream data.
- rd_valid  out  1  stream valid.
- rd_ready  in  1  downstream ready; transfer on rd_valid & rd_ready.
- rd_last  out  1  marks the final word of the burst.
- busy  out  1  high from command accept until the last word is transferred.

Behaviour:
- Reset (sync, sys_rst_n=0 at edge): FSM=IDLE; cmd_ready=0 during reset, 1 afterward in IDLE; rd_valid=0; rd_last=0; rd_data=0; busy=0; mem_addr=0; FIFO emptied; in-flight flag cleared. Reset mid-burst aborts: no further rd_valid, remaining words discarded.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On accept with cmd_len≠0: latch word=cmd_addr, remain=cmd_len, go to RUN, busy=1. On accept with cmd_len=0: consume the command, stay in IDLE, emit nothing, busy stays 0.
  - RUN: issue one read per cycle when (fifo_count + inflight) < 2 and remain≠0.
    - An issue drives mem_addr for the current word, sets inflight for the next cycle, increments word modulo 2^DEPTH_W, and decrements remain.
    - When remain reaches 0, go to DRAIN.
  - DRAIN: no issues. When the FIFO is empty, inflight=0 and the last word has been transferred, go to IDLE; busy=0 in that same cycle; cmd_ready=1 from the next cycle.
- Capture: mem_do is written into the FIFO in the cycle after an issue, tagged last=1 when that issue was the burst's final word.
- Output: rd_valid = FIFO non-empty; rd_data/rd_last come from the FIFO head. Once rd_valid is asserted, rd_data and rd_last hold stable until the transfer.
- Latency: first word reaches rd_valid=1 two cycles after command accept (issue at accept+1, capture at accept+2).
- Throughput: 1 word/cycle sustained with rd_ready held high.
- Backpressure: with rd_ready=0, at most 2 words are buffered and issues stall; no word is lost or duplicated.
- Simultaneous FIFO push and pop in the same cycle keeps the count unchanged.
- Wrap-around: the word address wraps from 2^DEPTH_W-1 to 0 inside a burst.
- Length 1024 reads the whole memory exactly once.
- cmd_ready=0 in RUN and DRAIN; commands presented then are held off, not dropped.
- Port A writes to an address in the same cycle as its port-B read: returned data is unspecified.

Test Plan:
- Memory at init pattern (byte d = d mod 256); cmd_addr=0, cmd_len=2, rd_ready=1 -> rd_data 0x03020100 then 0x07060504; rd_last on the 2nd only; first rd_valid 2 cycles after accept; busy falls after the last transfer.
- cmd_addr=1023, cmd_len=2 -> 0xFFFEFDFC then 0x03020100 (wrap); mem_addr sequence 0x7FE0, 0x0000.
- cmd_addr=4, cmd_len=8, rd_ready toggling 1,0,0,1,... -> exactly 8 words 0x13121110 .. 0x2F2E2D2C in order, no gaps or duplicates; stable data while stalled; never more than 2 issues outstanding.
- cmd_len=0 -> accepted in one cycle, no rd_valid, busy stays 0; cmd_len=1024 from addr 0 -> 1024 words, last = 0xFFFEFDFC with rd_last=1, 1024 transfers in 1026 cycles after accept.
- Assert sys_rst_n=0 during word 3 of an 8-word burst -> next cycle rd_valid=0, busy=0; after release cmd_ready=1; a new cmd (addr 0, len 1) returns 0x03020100.
- cmd_valid held high during an active burst -> second command accepted only after busy falls; its data follows the first burst with correct rd_last placement.
